// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 access-size codes
// and the control state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the LSU: store replication and write strobes, load lane
// extraction with sign/zero extension, and legality/alignment decode.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [31:0] wdata_out,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_out,
  output logic        err
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata_in[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata_in[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    wdata_out = wdata_in;
    wstrb     = 4'b0000;
    rdata_out = 32'h0;
    err       = 1'b0;
    unique case (funct3)
      F3_B: begin
        wdata_out = {4{wdata_in[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        rdata_out = {{24{rd_byte[7]}}, rd_byte};
      end
      F3_H: begin
        wdata_out = {2{wdata_in[15:0]}};
        wstrb     = 4'b0011 << addr_lo;
        rdata_out = {{16{rd_half[15]}}, rd_half};
        err       = addr_lo[0];
      end
      F3_W: begin
        wstrb     = 4'b1111;
        rdata_out = rdata_in;
        err       = |addr_lo;
      end
      F3_BU: begin
        rdata_out = {24'h0, rd_byte};
        err       = we;
      end
      F3_HU: begin
        rdata_out = {16'h0, rd_half};
        err       = we | addr_lo[0];
      end
      default: err = 1'b1;
    endcase
    // Loads never enable any write lane.
    if (!we) wstrb = 4'b0000;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time from execute, issues a single word-aligned
// valid/ready bus cycle toward data RAM, and returns extended load data or an error.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        idle;
  logic        ln_we;
  logic [2:0]  ln_funct3;
  logic [1:0]  ln_addr_lo;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_rdata;
  logic        lane_err;

  assign idle      = (state == IDLE);
  assign req_ready = idle & resetn;

  // The lane decodes the live request while idle and the latched request afterwards.
  assign ln_we      = idle ? req_we          : we_q;
  assign ln_funct3  = idle ? req_funct3      : funct3_q;
  assign ln_addr_lo = idle ? req_addr[1:0]   : addr_lo_q;

  lsu_lane u_lane (
    .funct3    (ln_funct3),
    .we        (ln_we),
    .addr_lo   (ln_addr_lo),
    .wdata_in  (req_wdata),
    .rdata_in  (mem_rdata),
    .wdata_out (lane_wdata),
    .wstrb     (lane_wstrb),
    .rdata_out (lane_rdata),
    .err       (lane_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = lane_err ? RESP : ACCESS;
      ACCESS:  if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          funct3_q  <= req_funct3;
          addr_lo_q <= req_addr[1:0];
          if (lane_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= lane_wdata;
            mem_wstrb <= lane_wstrb;
          end
        end
        ACCESS: if (mem_ready) begin
          mem_valid <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_q ? 32'h0 : lane_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the core: accepts one RISC-V load or store request at a time from the execute stage, drives the single-port valid/ready memory bus as initiator toward the data RAM, and returns sign/zero-extended load data or a completion strobe. It owns byte-lane steering, write-strobe generation and alignment checking. All accesses on the memory side are word-aligned.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_addr.

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-low.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data (0 for stores and errors).
- rsp_err  out  1  misaligned address or illegal funct3; qualified by rsp_valid.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accept/complete; the responder can assert it in the same cycle as mem_valid.
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0000 for loads.
- mem_rdata  in  32  read data, valid when mem_valid & mem_ready.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: decode funct3, check alignment, register the decoded request.
  - Legal funct3: loads 000,001,010,100,101; stores 000,001,010. Anything else is an error.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - On error, go to RESP with rsp_err=1. No bus cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS: mem_valid=1. mem_addr, mem_wdata and mem_wstrb come from registers and stay stable until mem_ready.
  - mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Store data: SB drives {4{wdata[7:0]}} with wstrb = 0001<<addr[1:0]. SH drives {2{wdata[15:0]}} with wstrb = 0011<<addr[1:0]. SW drives wdata with wstrb = 1111.
  - On mem_ready: capture the load lane and go to RESP.
  - Lane extraction: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend. LBU/LHU zero-extend. Stores capture 0.
- RESP: rsp_valid=1 for exactly one cycle, then back to IDLE. The consumer has no backpressure on the response.
- Only one outstanding transaction. req_ready=0 in ACCESS and RESP.

## Timing
- Reset (async, resetn=0): state=IDLE. mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=0 while resetn is low.
- Legal access with zero-wait responder: request accepted at cycle N; mem_valid=1 at N+1 with mem_ready=1 the same cycle; rsp_valid=1 at N+2. Next request can be accepted at N+3.
- Each wait cycle (mem_ready=0) adds one cycle; mem_valid stays high with all bus fields frozen.
- Error request: accepted at N; rsp_valid=1, rsp_err=1 at N+1; mem_valid never asserts.
- mem_valid drops in the cycle after mem_ready is seen. Back-to-back bus cycles are impossible.
- Reset during ACCESS: mem_valid deasserts immediately and asynchronously. The transaction is abandoned and no rsp_valid is produced. A store may or may not have committed.
- req_valid during ACCESS or RESP is ignored; the request must be held by the producer.
- All outputs are registered except req_ready, which decodes state.

## Structure
- lsu_pkg holds the funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and the state enum (IDLE, ACCESS, RESP).
- One combinational sub-module, lsu_lane, instantiated once. It takes funct3, addr[1:0] and raw data. It outputs the replicated wdata, the wstrb, the extracted and extended rdata, and the misalign/illegal flag.

## Test plan
- SW addr=0x104 data=0xDEADBEEF, zero-wait RAM -> mem_addr=0x104, wstrb=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept with rsp_err=0.
- SB addr=0x107 data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5; a following LW 0x104 returns 0xA5ADBEEF.
- LB/LBU/LH/LHU on word 0x80F0_7F01 at byte offsets 0..3, all legal combinations -> LB@3=0xFFFFFF80, LBU@3=0x00000080, LH@2=0xFFFF80F0, LHU@0=0x00007F01.
- LH addr=0x101, SW addr=0x102, funct3=011 load -> rsp_err=1 one cycle after accept; mem_valid stays 0.
- Responder holding mem_ready low for 3 cycles -> mem_valid and all bus fields stable for 4 cycles, rsp_valid exactly once, req_ready=0 throughout.
- resetn low during ACCESS -> mem_valid=0 within the same cycle, no rsp_valid, req_ready=1 in the first cycle after release.
